// File: rtl/fpu_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg
//   Shared single-precision format constants for the FPU conversion paths
//   (int->float and float->int), plus the stage payload types used by the
//   int->float pipeline and its round-to-nearest-even increment helper.
//
//   No ports (package).
// ----------------------------------------------------------------------------
package fpu_pkg;

    localparam int SGL_BIAS      = 127;
    localparam int SGL_EXP_W     = 8;
    localparam int SGL_MAN_W     = 23;
    localparam int INT_W         = 32;
    // Biased exponent of a value whose MSB sits at bit INT_W-1.
    localparam int ITOF_EXP_BASE = SGL_BIAS + INT_W - 1;

    // After S1: sign-magnitude form of the operand.
    typedef struct packed {
        logic             sign;
        logic             zero;
        logic [INT_W-1:0] mag;
    } itof_s1_t;

    // After S2: normalised magnitude. The leading one (bit INT_W-1) is
    // implicit and not stored; only the bits below it are kept.
    typedef struct packed {
        logic             sign;
        logic             zero;
        logic [4:0]       lz;
        logic [INT_W-2:0] n;
    } itof_s2_t;

    // Round-to-nearest-even increment: round up when above the halfway
    // point, or exactly halfway with an odd kept LSB.
    function automatic logic rne_inc(input logic lsb, input logic guard,
                                     input logic sticky);
        return guard & (sticky | lsb);
    endfunction

endpackage

// File: rtl/itof_pipe_lzc32.sv
// ----------------------------------------------------------------------------
// lzc32
//   Combinational 32-bit leading-zero counter used by the int->float
//   normaliser.
//
//   Ports:
//     a_i     in  32  operand
//     cnt_o   out 5   number of leading zeros (0..31); 0 when a_i is zero
//     zero_o  out 1   a_i is all zeros
// ----------------------------------------------------------------------------
module lzc32 (
    input  logic [31:0] a_i,
    output logic [4:0]  cnt_o,
    output logic        zero_o
);

    // Scan upward; the last set bit seen is the most significant one, so
    // its position wins.
    always_comb begin
        cnt_o = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (a_i[i]) begin
                cnt_o = 5'(31 - i);
            end
        end
    end

    assign zero_o = ~|a_i;

endmodule

// File: rtl/itof_pipe.sv
// ----------------------------------------------------------------------------
// itof_pipe
//   Three-stage pipelined 32-bit integer -> IEEE-754 single converter
//   (fcvt.s.w, and fcvt.s.wu when ITOF_UNSIGNED_EN is defined), rounding
//   round-to-nearest-even. An opaque tag travels alongside each operand.
//
//   Build option:
//     ITOF_UNSIGNED_EN  adds the 'uns' port; uns=1 converts x as unsigned.
//
//   Ports:
//     clk        in   1      clock, posedge
//     rstn       in   1      synchronous reset, active-low
//     in_valid   in   1      x/in_tag valid
//     in_ready   out  1      converter accepts input this cycle
//     x          in   32     integer operand
//     in_tag     in   TAG_W  tag for x
//     uns        in   1      (ITOF_UNSIGNED_EN only) treat x as unsigned
//     out_valid  out  1      y/out_tag valid
//     out_ready  in   1      consumer accepts y this cycle
//     y          out  32     single-precision result
//     out_tag    out  TAG_W  tag matching y
//
//   Handshake: a transfer happens on a posedge where valid & ready are both
//   high. The whole pipe moves together (adv = ~out_valid | out_ready); while
//   the output is held, every stage, y and out_tag are frozen and in_ready is
//   low. Bubbles are carried, not squeezed out.
// ----------------------------------------------------------------------------
module itof_pipe
    import fpu_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] x,
    input  logic [TAG_W-1:0] in_tag,
`ifdef ITOF_UNSIGNED_EN
    input  logic             uns,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic [TAG_W-1:0] out_tag
);

    logic adv;

    // Stage valid bits and output registers (reset).
    logic             v1_q, v2_q, out_valid_q;
    logic [31:0]      y_q;
    logic [TAG_W-1:0] out_tag_q;

    // Stage payloads (no reset; qualified by the valid bits).
    itof_s1_t         s1_d, s1_q;
    itof_s2_t         s2_d, s2_q;
    logic [TAG_W-1:0] tag1_q, tag2_q;
    logic [31:0]      y_d;

    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    // ------------------------------------------------------------------
    // S1: sign-magnitude. -2^31 negates to itself, which is exactly the
    // magnitude 0x80000000 when read as unsigned.
    // ------------------------------------------------------------------
    logic neg;
`ifdef ITOF_UNSIGNED_EN
    assign neg = x[INT_W-1] & ~uns;
`else
    assign neg = x[INT_W-1];
`endif

    always_comb begin
        s1_d      = '0;
        s1_d.sign = neg;
        s1_d.zero = (x == '0);
        s1_d.mag  = neg ? -x : x;
    end

    // ------------------------------------------------------------------
    // S2: normalise so the leading one lands on bit 31.
    // ------------------------------------------------------------------
    logic [4:0] lz;
    logic       lzc_zero;

    lzc32 u_lzc (
        .a_i    (s1_q.mag),
        .cnt_o  (lz),
        .zero_o (lzc_zero)
    );

    always_comb begin
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        // Both flags flag the same condition; either forces a +0 result.
        s2_d.zero = s1_q.zero | lzc_zero;
        s2_d.lz   = lz;
        s2_d.n    = (INT_W-1)'(s1_q.mag << lz);
    end

    // ------------------------------------------------------------------
    // S3: round to 24 significant bits (RNE) and pack. A mantissa carry
    // out bumps the exponent; the low 23 sum bits are then already zero.
    // The largest magnitude (2^32-1, unsigned) rounds to exponent 159,
    // still well inside the 8-bit field, so no overflow case exists.
    // ------------------------------------------------------------------
    logic [SGL_MAN_W-1:0] mant;
    logic                 rnd;
    logic [SGL_MAN_W:0]   sum;
    logic [SGL_EXP_W-1:0] exp8;

    always_comb begin
        mant = s2_q.n[INT_W-2 -: SGL_MAN_W];
        rnd  = rne_inc(s2_q.n[INT_W-1-SGL_MAN_W],
                       s2_q.n[INT_W-2-SGL_MAN_W],
                       |s2_q.n[INT_W-3-SGL_MAN_W:0]);
        sum  = {1'b0, mant} + {{SGL_MAN_W{1'b0}}, rnd};
        exp8 = SGL_EXP_W'(ITOF_EXP_BASE) - {3'b000, s2_q.lz}
             + {{(SGL_EXP_W-1){1'b0}}, sum[SGL_MAN_W]};
        y_d  = s2_q.zero ? 32'h0000_0000
                         : {s2_q.sign, exp8, sum[SGL_MAN_W-1:0]};
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            out_tag_q   <= '0;
        end else if (adv) begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            y_q         <= y_d;
            out_tag_q   <= tag2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_q   <= s1_d;
            tag1_q <= in_tag;
            s2_q   <= s2_d;
            tag2_q <= tag1_q;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_itof_pipe.sv
// ----------------------------------------------------------------------------
// tb_itof_pipe
//   Self-checking bench for itof_pipe. Accepted operands push their expected
//   {tag, y} into exp_q; a monitor pops and compares whenever an output
//   transfer occurs. Random operands are checked against an arithmetic
//   reference conversion. Define ITOF_UNSIGNED_EN to exercise the unsigned
//   build.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_itof_pipe;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      x;
    logic [TAG_W-1:0] in_tag;
    logic             uns_drv;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      y;
    logic [TAG_W-1:0] out_tag;

    itof_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .in_tag    (in_tag),
`ifdef ITOF_UNSIGNED_EN
        .uns       (uns_drv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_tag   (out_tag)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [TAG_W+31:0] exp_q[$];
    int                acc_cyc_q[$];
    int                pop_cyc_q[$];
    int                n_cmp = 0;
    int                n_err = 0;
    logic [TAG_W-1:0]  tag_ctr = '0;
    bit                rnd_done;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    // Plain arithmetic: find the top set bit, keep 24 significant bits,
    // round the discarded remainder to nearest, ties to even.
    function automatic logic [31:0] ref_itof(input logic [31:0] xv, input bit u);
        bit     s;
        longint v, q, rem, half;
        int     e, sh;
        s = xv[31] && !u;
        v = longint'({32'h0, xv});
        if (s) v = 64'sd4294967296 - v;
        if (v == 0) return 32'h0000_0000;
        e = 0;
        while ((v >> (e + 1)) != 0) e++;
        if (e <= 23) begin
            q = v << (23 - e);
        end else begin
            sh   = e - 23;
            q    = v >> sh;
            rem  = v - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                e++;
            end
        end
        return {s, 8'(e + 127), q[22:0]};
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [31:0] xv, input bit u, input logic [31:0] ey);
        int waited = 0;
        in_valid = 1'b1;
        x        = xv;
        in_tag   = tag_ctr;
        uns_drv  = u;
        forever begin
            #1;
            if (in_ready) break;
            if (waited == 1000) begin
                fail_now("accept_timeout");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            waited++;
        end
        exp_q.push_back({tag_ctr, ey});
        acc_cyc_q.push_back(cyc);
        tag_ctr++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0) begin
            if (n == 500) begin
                fail_now("drain_timeout");
                exp_q.delete();
                break;
            end
            @(negedge clk);
            #2;
            n++;
        end
    endtask

    task automatic check_latency(input string name, input int count);
        if (acc_cyc_q.size() != count || pop_cyc_q.size() != count) begin
            fail_now({name, "_count"});
        end else begin
            for (int i = 0; i < count; i++) begin
                check(name, 32'(pop_cyc_q[i] - acc_cyc_q[i]), 32'd3);
            end
        end
    endtask

    task automatic clear_timing();
        acc_cyc_q.delete();
        pop_cyc_q.delete();
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic              stall_prev;
        logic [31:0]       y_prev;
        logic [TAG_W-1:0]  tag_prev;
        logic [TAG_W+31:0] e;
        stall_prev = 1'b0;
        y_prev     = '0;
        tag_prev   = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rstn) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", {31'b0, out_valid}, 32'd1);
                    check("hold_y", y, y_prev);
                    check("hold_tag", {27'b0, out_tag}, {27'b0, tag_prev});
                end
                stall_prev = 1'b0;
                if (out_valid) begin
                    if (!out_ready) begin
                        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
                        stall_prev = 1'b1;
                        y_prev     = y;
                        tag_prev   = out_tag;
                    end else if (exp_q.size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        e = exp_q.pop_front();
                        check("y", y, e[31:0]);
                        check("tag", {27'b0, out_tag}, {27'b0, e[TAG_W+31:32]});
                        pop_cyc_q.push_back(cyc);
                    end
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- random operand generator ----------------
    task automatic gen(output logic [31:0] xv, output bit u);
        logic [31:0] m;
        int          k;
        logic [31:0] sp[6];
        sp[0] = 32'h0000_0000;
        sp[1] = 32'h8000_0000;
        sp[2] = 32'h7FFF_FFFF;
        sp[3] = 32'hFFFF_FFFF;
        sp[4] = 32'h0000_0001;
        sp[5] = 32'h00FF_FFFF;
        case ($urandom_range(0, 4))
            0: xv = $urandom;
            1: xv = $urandom_range(0, 32'h00FF_FFFF);
            2: begin
                // Exact halfway remainder below a 24-bit mantissa.
                k  = $urandom_range(1, 7);
                m  = 32'h0080_0000 | $urandom_range(0, 32'h007F_FFFF);
                xv = (m << k) | (32'h1 << (k - 1));
            end
            3: xv = sp[$urandom_range(0, 5)];
            default: xv = $urandom >> $urandom_range(0, 31);
        endcase
        if ($urandom_range(0, 1) == 1) xv = -xv;
`ifdef ITOF_UNSIGNED_EN
        u = bit'($urandom_range(0, 1));
`else
        u = 1'b0;
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin : stim
        logic [31:0] xv;
        bit          u;

        rstn      = 1'b0;
        in_valid  = 1'b0;
        x         = '0;
        in_tag    = '0;
        uns_drv   = 1'b0;
        out_ready = 1'b1;
        rnd_done  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_out_tag", {27'b0, out_tag}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;

        // 1) back-to-back, fixed latency, consecutive outputs
        clear_timing();
        send(32'd1, 1'b0, 32'h3F80_0000);
        send(32'hFFFF_FFFF, 1'b0, 32'hBF80_0000);
        send(32'd0, 1'b0, 32'h0000_0000);
        wait_drain();
        check_latency("lat_b2b", 3);
        if (pop_cyc_q.size() == 3) begin
            check("consec_1", 32'(pop_cyc_q[1] - pop_cyc_q[0]), 32'd1);
            check("consec_2", 32'(pop_cyc_q[2] - pop_cyc_q[1]), 32'd1);
        end

        // 2) rounding boundaries, 3) range boundaries
        @(negedge clk);
        send(32'h0100_0001, 1'b0, 32'h4B80_0000);
        send(32'h0100_0003, 1'b0, 32'h4B80_0002);
        send(32'h7FFF_FFFF, 1'b0, 32'h4F00_0000);
        send(32'h8000_0000, 1'b0, 32'hCF00_0000);
        send(-32'd16777217, 1'b0, 32'hCB80_0000);
        send(32'd123456789, 1'b0, 32'h4CEB_79A3);
        send(32'h00FF_FFFF, 1'b0, 32'h4B7F_FFFF);
`ifdef ITOF_UNSIGNED_EN
        // 6) unsigned conversions
        send(32'hFFFF_FFFF, 1'b1, 32'h4F80_0000);
        send(32'h8000_0000, 1'b1, 32'h4F00_0000);
        send(32'hFFFF_FFFF, 1'b0, 32'hBF80_0000);
`endif
        wait_drain();

        // 4) stream of 6 with a 4-cycle output stall in the middle
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    xv = $urandom;
                    send(xv, 1'b0, ref_itof(xv, 1'b0));
                end
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // 5) reset with three conversions in flight
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            xv = $urandom;
            send(xv, 1'b0, ref_itof(xv, 1'b0));
        end
        #1;
        check("inflight_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        exp_q.delete();
        clear_timing();
        rstn      = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst_valid", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_quiet", {31'b0, out_valid}, 32'd0);
        end
        @(negedge clk);
        send(32'hFFFF_FF85, 1'b0, 32'hC2F6_0000);
        wait_drain();
        check_latency("lat_after_rst", 1);

        // Random sweep with random output back-pressure and input gaps
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    gen(xv, u);
                    send(xv, u, ref_itof(xv, u));
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
